// File: rtl/resource_arbiter.sv
// resource_arbiter: round-robin arbiter that lets n_req requesters share one
// downstream command/response port, with one transaction in flight at a time.
// Each transaction is issued with a valid/ready handshake and then waits for
// its completion. If no completion arrives within 'timeout' cycles, the
// transaction is forced to complete.
module resource_arbiter #(
   parameter int data_width   = 16,
   parameter int handle_width = 8,
   parameter int n_req        = 4,
   parameter int timeout      = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [n_req-1:0]              req_read,
   input  logic [n_req-1:0]              req_write,
   input  logic [n_req*handle_width-1:0] req_handle,
   input  logic [n_req*data_width-1:0]   req_arg_a,
   input  logic [n_req*data_width-1:0]   req_arg_b,
   output logic [data_width-1:0]         rsp_data,
   output logic [n_req-1:0]              rsp_read_ready,
   output logic [n_req-1:0]              rsp_write_ack,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic                          res_write,
   output logic [handle_width-1:0]       res_handle,
   output logic [data_width-1:0]         res_arg_a,
   output logic [data_width-1:0]         res_arg_b,
   input  logic                          res_rdata_valid,
   input  logic [data_width-1:0]         res_rdata,
   input  logic                          res_wack,
   output logic                          busy,
   output logic [2:0]                    grant_id,
   output logic                          timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              gnt_q, gnt_d;
   logic [2:0]              last_q, last_d;
   logic                    wr_q, wr_d;
   logic [handle_width-1:0] hdl_q, hdl_d;
   logic [data_width-1:0]   arga_q, arga_d;
   logic [data_width-1:0]   argb_q, argb_d;
   logic [data_width-1:0]   rdata_q, rdata_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    terr_q, terr_d;

   // Arbitration signals. Padding to 8 bits lets a 3-bit index reach any requester.
   logic [7:0]              pend8, wr8;
   logic [3:0]              idx;
   logic                    found;
   logic [2:0]              win;
   logic [handle_width-1:0] sel_hdl;
   logic [data_width-1:0]   sel_a, sel_b;
   logic [n_req-1:0]        oh;
   logic                    done;

   // Round-robin search beginning just after the last grant, then a mux of the winner's fields.
   always_comb begin
      pend8 = '0;
      wr8   = '0;
      pend8[n_req-1:0] = req_read | req_write;
      wr8[n_req-1:0]   = req_write;
      found   = 1'b0;
      win     = '0;
      idx     = '0;
      sel_hdl = '0;
      sel_a   = '0;
      sel_b   = '0;
      for (int k = 1; k <= n_req; k++) begin
         idx = {1'b0, last_q} + 4'(k);
         if (idx >= 4'(n_req)) idx = idx - 4'(n_req);
         if (!found && pend8[idx[2:0]]) begin
            found = 1'b1;
            win   = idx[2:0];
         end
      end
      for (int i = 0; i < n_req; i++) begin
         if (win == 3'(i)) begin
            sel_hdl = req_handle[i*handle_width +: handle_width];
            sel_a   = req_arg_a[i*data_width +: data_width];
            sel_b   = req_arg_b[i*data_width +: data_width];
         end
      end
   end

   // Accept only the completion type that matches the transaction; ignore the other type.
   assign done = wr_q ? res_wack : res_rdata_valid;

   // Next-state logic. While enable is low, every register holds its value.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wr_d    = wr_q;
      hdl_d   = hdl_q;
      arga_d  = arga_q;
      argb_d  = argb_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      if (enable) begin
         case (state_q)
            IDLE: if (found) begin
               gnt_d   = win;
               last_d  = win;
               wr_d    = wr8[win];
               hdl_d   = sel_hdl;
               arga_d  = sel_a;
               argb_d  = sel_b;
               state_d = ISSUE;
            end
            ISSUE: if (res_ready) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
            WAIT: begin
               cnt_d = cnt_q + 8'd1;
               if (done) begin
                  // A completion in the same cycle as the limit takes priority over the timeout.
                  if (!wr_q) rdata_d = res_rdata;
                  state_d = RESP;
               end else if (cnt_q == 8'(timeout - 1)) begin
                  terr_d = 1'b1;
                  if (!wr_q) rdata_d = '0;
                  state_d = RESP;
               end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers. Synchronous reset makes the last grant point at the top requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= 3'(n_req - 1);
         wr_q    <= 1'b0;
         hdl_q   <= '0;
         arga_q  <= '0;
         argb_q  <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
         hdl_q   <= hdl_d;
         arga_q  <= arga_d;
         argb_q  <= argb_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   // One-hot decode of the granted requester, used for the response pulse.
   always_comb begin
      oh = '0;
      for (int i = 0; i < n_req; i++) oh[i] = (gnt_q == 3'(i));
   end

   // Pulses are gated by enable, so a frozen RESP cycle produces no new pulse.
   assign rsp_read_ready = (state_q == RESP && enable && !wr_q) ? oh : '0;
   assign rsp_write_ack  = (state_q == RESP && enable &&  wr_q) ? oh : '0;
   assign res_valid      = (state_q == ISSUE);
   assign res_write      = wr_q;
   assign res_handle     = hdl_q;
   assign res_arg_a      = arga_q;
   assign res_arg_b      = argb_q;
   assign rsp_data       = rdata_q;
   assign busy           = (state_q != IDLE);
   assign grant_id       = gnt_q;
   assign timeout_err    = terr_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter. It covers reset, single read,
// round-robin order, write with backpressure, completion at the timeout limit,
// timeout, reset mid-transaction, enable freeze and skipping a dropped request.
module tb_resource_arbiter;
   localparam int N = 4, DW = 16, HW = 8;

   logic          clk = 1'b0, reset, enable;
   logic [N-1:0]  req_read, req_write;
   logic [N*HW-1:0] req_handle;
   logic [N*DW-1:0] req_arg_a, req_arg_b;
   logic [DW-1:0] rsp_data;
   logic [N-1:0]  rsp_read_ready, rsp_write_ack;
   logic          res_valid, res_ready, res_write;
   logic [HW-1:0] res_handle;
   logic [DW-1:0] res_arg_a, res_arg_b;
   logic          res_rdata_valid, res_wack;
   logic [DW-1:0] res_rdata;
   logic          busy, timeout_err;
   logic [2:0]    grant_id;

   int errors = 0, checks = 0;

   resource_arbiter #(.data_width(DW), .handle_width(HW), .n_req(N), .timeout(255)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req_read(req_read), .req_write(req_write), .req_handle(req_handle),
      .req_arg_a(req_arg_a), .req_arg_b(req_arg_b),
      .rsp_data(rsp_data), .rsp_read_ready(rsp_read_ready), .rsp_write_ack(rsp_write_ack),
      .res_valid(res_valid), .res_ready(res_ready), .res_write(res_write),
      .res_handle(res_handle), .res_arg_a(res_arg_a), .res_arg_b(res_arg_b),
      .res_rdata_valid(res_rdata_valid), .res_rdata(res_rdata), .res_wack(res_wack),
      .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1;
      req_read = '0; req_write = '0;
      req_handle = '0; req_arg_a = '0; req_arg_b = '0;
      res_ready = 1'b0; res_rdata_valid = 1'b0; res_rdata = '0; res_wack = 1'b0;
      req_handle[0*HW +: HW] = 8'hA0;
      req_handle[1*HW +: HW] = 8'h3C;
      req_handle[2*HW +: HW] = 8'h05;
      req_handle[3*HW +: HW] = 8'hD3;
      req_arg_a[1*DW +: DW] = 16'h7FFF;
      req_arg_b[1*DW +: DW] = 16'h8000;

      // Reset state
      tick; tick;
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_pulse", {rsp_read_ready, rsp_write_ack}, 0);
      reset = 1'b0;

      // Single read from requester 2
      req_read = 4'b0100; res_ready = 1'b1;
      tick;
      chk("rd_valid", res_valid, 1);
      chk("rd_handle", res_handle, 8'h05);
      chk("rd_write", res_write, 0);
      chk("rd_gid", grant_id, 2);
      chk("rd_busy", busy, 1);
      tick;
      chk("rd_valid_drop", res_valid, 0);
      chk("rd_no_early", rsp_read_ready, 0);
      res_rdata_valid = 1'b1; res_rdata = 16'h1234;
      tick;
      res_rdata_valid = 1'b0;
      chk("rd_pulse", rsp_read_ready, 4'b0100);
      chk("rd_data", rsp_data, 16'h1234);
      req_read = '0;
      tick;
      chk("rd_pulse_end", rsp_read_ready, 0);
      chk("rd_idle", busy, 0);
      chk("rd_hold", rsp_data, 16'h1234);

      // Round-robin after a fresh reset: expected order 0,1,2,3,0
      reset = 1'b1; tick; reset = 1'b0;
      req_read = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("rr_gid", grant_id, k % 4);
         tick;
         res_rdata_valid = 1'b1; res_rdata = 16'(16'h1000 + k);
         tick;
         res_rdata_valid = 1'b0;
         chk("rr_pulse", rsp_read_ready, 32'(1) << (k % 4));
         chk("rr_data", rsp_data, 16'h1000 + k);
         tick;
      end
      req_read = '0;

      // Write with backpressure, requester 1 (last grant was 0)
      req_write = 4'b0010; res_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick; else tick;
         if (c == 3) res_ready = 1'b1;
         chk("wr_valid", res_valid, 1);
         chk("wr_fields", {res_write, res_handle, res_arg_a, res_arg_b}, {1'b1, 8'h3C, 16'h7FFF, 16'h8000});
      end
      tick;
      chk("wr_accepted", res_valid, 0);
      res_rdata_valid = 1'b1; res_rdata = 16'hDEAD;
      tick;
      res_rdata_valid = 1'b0;
      chk("wr_ignore_rd", {busy, rsp_write_ack, rsp_read_ready}, {1'b1, 8'h00});
      res_wack = 1'b1;
      tick;
      res_wack = 1'b0;
      chk("wr_ack", rsp_write_ack, 4'b0010);
      chk("wr_no_rd", rsp_read_ready, 0);
      chk("wr_data_hold", rsp_data, 16'h1004);
      req_write = '0;
      tick;
      chk("wr_ack_end", rsp_write_ack, 0);

      // Read and write both high selects a write; completion exactly at the limit wins
      req_read = 4'b0100; req_write = 4'b0100;
      tick;
      chk("dual_gid", grant_id, 2);
      chk("dual_is_write", res_write, 1);
      tick;
      repeat (254) tick;
      chk("lim_no_pulse", rsp_write_ack, 0);
      res_wack = 1'b1;
      tick;
      res_wack = 1'b0;
      chk("lim_ack", rsp_write_ack, 4'b0100);
      chk("lim_no_terr", timeout_err, 0);
      req_read = '0; req_write = '0;
      tick;

      // Timeout on a read from requester 3
      req_read = 4'b1000;
      tick;
      chk("to_gid", grant_id, 3);
      tick;
      repeat (254) tick;
      chk("to_not_yet", {rsp_read_ready, timeout_err}, 0);
      tick;
      chk("to_pulse", rsp_read_ready, 4'b1000);
      chk("to_data", rsp_data, 0);
      chk("to_terr", timeout_err, 1);
      req_read = '0;
      tick; tick;
      chk("to_sticky", timeout_err, 1);

      // Reset in WAIT, then a late completion in IDLE
      req_read = 4'b0010;
      tick; tick;
      chk("rw_busy", busy, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0; req_read = '0;
      chk("rw_valid_drop", res_valid, 0);
      res_rdata_valid = 1'b1; res_rdata = 16'h5555;
      tick;
      res_rdata_valid = 1'b0;
      chk("rw_no_pulse", {rsp_read_ready, rsp_write_ack}, 0);
      chk("rw_idle", busy, 0);
      chk("rw_data", rsp_data, 0);
      chk("rw_terr", timeout_err, 0);
      req_read = 4'b1111;
      tick;
      chk("rw_gid0", grant_id, 0);

      // enable low for 5 cycles while in ISSUE
      enable = 1'b0; res_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick;
         chk("en_frozen", {res_valid, busy, grant_id, res_handle}, {1'b1, 1'b1, 3'd0, 8'hA0});
      end
      enable = 1'b1;
      tick;
      chk("en_accept", res_valid, 0);
      res_rdata_valid = 1'b1; res_rdata = 16'hBEEF;
      tick;
      res_rdata_valid = 1'b0;
      chk("en_pulse", rsp_read_ready, 4'b0001);
      chk("en_data", rsp_data, 16'hBEEF);
      req_read = '0;
      tick;

      // A requester that drops before grant is skipped (last grant 0)
      enable = 1'b0; req_read = 4'b0010;
      tick;
      chk("skip_frozen", busy, 0);
      enable = 1'b1; req_read = 4'b1000;
      tick;
      chk("skip_gid", grant_id, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/resource_arbiter.md
RESOURCE_ARBITER -- requirements
Module: resource_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- data_width, 16, width of args and read data.
- handle_width, 8, width of resource handle.
- n_req, 4, number of requesters (2..8).
- timeout, 255, max WAIT cycles before forced completion (1..255).

REQ-002 SHALL have ports, one per line:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global advance; when low all state and outputs hold.
- req_read  in  n_req  per-requester read request, level-held until served.
- req_write  in  n_req  per-requester write request, level-held until served.
- req_handle  in  n_req*handle_width  packed handles; requester i at slice i.
- req_arg_a  in  n_req*data_width  packed arg A.
- req_arg_b  in  n_req*data_width  packed arg B.
- rsp_data  out  data_width  read data, broadcast to all requesters.
- rsp_read_ready  out  n_req  one-hot one-cycle read completion pulse.
- rsp_write_ack  out  n_req  one-hot one-cycle write completion pulse.
- res_valid  out  1  downstream command valid.
- res_ready  in  1  downstream command accept.
- res_write  out  1  command is a write.
- res_handle  out  handle_width  command handle.
- res_arg_a  out  data_width  command arg A.
- res_arg_b  out  data_width  command arg B.
- res_rdata_valid  in  1  downstream read data valid, one cycle.
- res_rdata  in  data_width  downstream read data.
- res_wack  in  1  downstream write done, one cycle.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  3  index of current or last granted requester.
- timeout_err  out  1  sticky; set on any timeout.

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, RESP; only one transaction in flight.
REQ-004 IDLE: requester i is pending when req_read[i] or req_write[i] is high; with any pending, latch the winner's handle, args, write bit and index, then go to ISSUE.
REQ-005 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod n_req; last_grant updates at grant.
REQ-006 If req_read[i] and req_write[i] are both high, the transaction SHALL be a write.
REQ-007 ISSUE: res_valid high with latched fields stable; on res_valid && res_ready, go to WAIT and clear the timeout counter.
REQ-008 WAIT: counter increments each enabled cycle.
- Read completion is res_rdata_valid: latch res_rdata into rsp_data, go to RESP.
- Write completion is res_wack: go to RESP.
- Completion signal of the wrong type SHALL be ignored.
REQ-009 WAIT timeout: when the counter reaches timeout without completion, set timeout_err, force rsp_data=0 for reads, and go to RESP.
REQ-010 RESP: for exactly one cycle, assert rsp_read_ready[g] (read) or rsp_write_ack[g] (write), where g is the granted index; then go to IDLE.
REQ-011 A completion arriving in the same cycle as the timeout limit SHALL win: data is taken and timeout_err is not set.
REQ-012 Latency SHALL be: grant in cycle 0, res_valid from cycle 1, response pulse exactly one cycle after completion. With res_ready=1 and 1-cycle memory, read-to-pulse is 4 cycles.
REQ-013 rsp_data SHALL hold its value until the next read completion.
REQ-014 Requesters that drop their request before grant SHALL be skipped without penalty.
REQ-015 The IDLE cycle after RESP SHALL re-arbitrate; the just-served requester is lowest priority.
REQ-016 enable low SHALL freeze state, counter and outputs, and suppress new pulses.

Reset
REQ-017 reset SHALL force IDLE, last_grant=n_req-1, grant_id=0, and all outputs 0 (including timeout_err and rsp_data).
REQ-018 reset mid-transaction SHALL drop res_valid the next cycle, emit no response pulse, and discard any late completion arriving while in IDLE.

Verification
REQ-019 Single read: req_read[2]=1, handle 0x05, res_ready=1, res_rdata=0x1234 one cycle after accept -> res_handle=0x05, rsp_read_ready=4'b0100 single pulse, rsp_data=0x1234.
REQ-020 Round-robin: req_read=4'b1111 held and re-asserted after each pulse -> grant order 0,1,2,3,0.
REQ-021 Write with backpressure: req_write[1]=1, args A=0x7FFF, B=0x8000, res_ready low 3 cycles -> res_valid and fields stable 4 cycles, rsp_write_ack=4'b0010 one cycle after res_wack.
REQ-022 Timeout: read issued, no res_rdata_valid for 255 cycles -> rsp_read_ready pulse, rsp_data=0, timeout_err=1 and stays set until reset.
REQ-023 Reset in WAIT, then res_rdata_valid -> no pulse, busy=0, next grant goes to requester 0.
REQ-024 enable held low 5 cycles in ISSUE -> all outputs unchanged; transaction completes normally after enable returns.
